// File: rtl/ex_macc_pkg.sv
// ----------------------------------------------------------------------------
// ex_macc_pkg : shared widths, op encodings and FSM states for ex_macc
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ex_macc_pkg;

    localparam int REG_BUS    = 32;
    localparam int DOUBLE_BUS = 64;

    typedef logic [1:0] macc_op_t;

    localparam macc_op_t MADD  = 2'b00;
    localparam macc_op_t MADDU = 2'b01;
    localparam macc_op_t MSUB  = 2'b10;
    localparam macc_op_t MSUBU = 2'b11;

    typedef enum logic [1:0] {
        MaccIdle = 2'd0,
        MaccMul  = 2'd1,
        MaccAcc  = 2'd2,
        MaccDone = 2'd3
    } macc_state_e;

    // bit 0 selects unsigned operands, bit 1 selects subtraction
    function automatic logic op_is_signed(input macc_op_t op);
        return ~op[0];
    endfunction

    function automatic logic op_is_sub(input macc_op_t op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_macc_mul32.sv
// ----------------------------------------------------------------------------
// macc_mul32 : registered 32x32 multiplier, signed/unsigned select, 64b result
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module macc_mul32
    import ex_macc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  signed_i,
    input  logic [REG_BUS-1:0]    a_i,
    input  logic [REG_BUS-1:0]    b_i,
    output logic [DOUBLE_BUS-1:0] p_o
);

    logic [DOUBLE_BUS-1:0] a_ext_w;
    logic [DOUBLE_BUS-1:0] b_ext_w;
    logic [DOUBLE_BUS-1:0] p_q;

    // Low 64 bits of a 64x64 product of sign/zero-extended operands equal the
    // true 32x32 signed or unsigned product.
    assign a_ext_w = {{REG_BUS{signed_i & a_i[REG_BUS-1]}}, a_i};
    assign b_ext_w = {{REG_BUS{signed_i & b_i[REG_BUS-1]}}, b_i};

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= a_ext_w * b_ext_w;
        end
    end

    assign p_o = p_q;

endmodule

`default_nettype wire

// File: rtl/ex_macc.sv
// ----------------------------------------------------------------------------
// ex_macc  : multi-cycle MADD/MADDU/MSUB/MSUBU sequencer for the EX stage
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ex_macc
    import ex_macc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [REG_BUS-1:0] reg1,
    input  logic [REG_BUS-1:0] reg2,
    input  logic [REG_BUS-1:0] hi_i,
    input  logic [REG_BUS-1:0] lo_i,
    input  logic               hold,
    input  logic               flush,
    output logic               stallreq,
    output logic               whilo,
    output logic [REG_BUS-1:0] hi_o,
    output logic [REG_BUS-1:0] lo_o
);

    macc_state_e           state_q;
    macc_op_t              op_q;
    logic                  whilo_q;
    logic [REG_BUS-1:0]    hi_q;
    logic [REG_BUS-1:0]    lo_q;
    logic [DOUBLE_BUS-1:0] prod_w;
    logic [DOUBLE_BUS-1:0] acc_d;
    logic                  mul_signed_w;
    logic                  mul_en_w;

    // op is not latched until the launch edge, so the first product uses the live op
    assign mul_signed_w = (state_q == MaccIdle) ? op_is_signed(op) : op_is_signed(op_q);
    assign mul_en_w     = (state_q == MaccIdle) || (state_q == MaccMul);

    macc_mul32 u_mul (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (flush),
        .en_i     (mul_en_w),
        .signed_i (mul_signed_w),
        .a_i      (reg1),
        .b_i      (reg2),
        .p_o      (prod_w)
    );

    // HI/LO are read in ACC so results retiring from MEM/WB are already forwarded
    assign acc_d = op_is_sub(op_q) ? ({hi_i, lo_i} - prod_w)
                                   : ({hi_i, lo_i} + prod_w);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= MaccIdle;
            op_q    <= MADD;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                MaccIdle: begin
                    if (start && !hold) begin
                        op_q    <= op;
                        state_q <= MaccMul;
                    end
                end
                MaccMul: begin
                    state_q <= MaccAcc;
                end
                MaccAcc: begin
                    whilo_q <= 1'b1;
                    hi_q    <= acc_d[DOUBLE_BUS-1:REG_BUS];
                    lo_q    <= acc_d[REG_BUS-1:0];
                    state_q <= MaccDone;
                end
                MaccDone: begin
                    if (!hold) begin
                        whilo_q <= 1'b0;
                        hi_q    <= '0;
                        lo_q    <= '0;
                        state_q <= MaccIdle;
                    end
                end
                default: begin
                    state_q <= MaccIdle;
                end
            endcase
        end
    end

    assign stallreq = !rst && ((state_q == MaccIdle) ? start : (state_q != MaccDone));
    assign whilo    = !rst && whilo_q;
    assign hi_o     = rst ? '0 : hi_q;
    assign lo_o     = rst ? '0 : lo_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_macc.sv
// ----------------------------------------------------------------------------
// tb_ex_macc : randomized scoreboard bench for ex_macc
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ex_macc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        hold;
    logic        flush;
    logic        stallreq;
    logic        whilo;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int passes = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ex_macc dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .reg1     (reg1),
        .reg2     (reg2),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .hold     (hold),
        .flush    (flush),
        .stallreq (stallreq),
        .whilo    (whilo),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, exp, $time);
    endtask

    // Reference: HI:LO plus or minus the exact product, modulo 2^64
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, b, hi, lo);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        if (o[0]) p = {32'd0, a} * {32'd0, b};
        else      p = sa * sb;
        return o[1] ? ({hi, lo} - p) : ({hi, lo} + p);
    endfunction

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input logic exp_stall, input logic exp_whilo);
        @(negedge clk);
        chk({name, ".stallreq"}, {63'd0, stallreq}, {63'd0, exp_stall});
        chk({name, ".whilo"},    {63'd0, whilo},    {63'd0, exp_whilo});
    endtask

    // One full instruction: optional IDLE hold, T..T+2 stall, DONE with dhold, then IDLE
    task automatic txn(input logic [1:0] o, input logic [31:0] a, b, hi, lo, pre_hi, pre_lo,
                       input int pre_hold, input int dhold, input bit rnd_mid_hold);
        start = 1'b1; op = o; reg1 = a; reg2 = b; hi_i = pre_hi; lo_i = pre_lo;
        hold = 1'b1;
        repeat (pre_hold) begin
            chk_ctl("idle_hold", 1'b1, 1'b0);
            nx();
        end
        hold = 1'b0;
        chk_ctl("T", 1'b1, 1'b0);
        nx();
        op = 2'($urandom);
        hold = rnd_mid_hold ? 1'($urandom) : 1'b0;
        chk_ctl("T1", 1'b1, 1'b0);
        nx();
        hi_i = hi; lo_i = lo;
        hold = rnd_mid_hold ? 1'($urandom) : 1'b0;
        exp_q.push_back(model(o, a, b, hi, lo));
        chk_ctl("T2", 1'b1, 1'b0);
        nx();
        hi_i = $urandom; lo_i = $urandom;
        hold = (dhold > 0);
        repeat (dhold) begin
            chk_ctl("done_hold", 1'b0, 1'b0 | 1'b1);
            nx();
        end
        hold = 1'b0;
        chk_ctl("T3", 1'b0, 1'b1);
        nx();
        start = 1'b0;
        chk_ctl("after", 1'b0, 1'b0);
        nx();
    endtask

    // Scoreboard monitor: compare every DONE cycle, retire when EX/MEM accepts
    always @(negedge clk) begin
        if (!rst && whilo) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_whilo", {32'd0, hi_o} ^ {32'd0, lo_o}, 64'hDEAD_0000_0000_BEEF);
            end else begin
                chk("result", {hi_o, lo_o}, exp_q[0]);
                if (!hold) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; reg1 = '0; reg2 = '0;
        hi_i = '0; lo_i = '0; hold = 1'b0; flush = 1'b0;
        nx(); nx();
        start = 1'b1;
        @(negedge clk);
        chk("rst.stallreq", {63'd0, stallreq}, 64'd0);
        chk("rst.out", {31'd0, whilo, hi_o, lo_o} , 64'd0);
        nx();
        rst = 1'b0; start = 1'b0;
        chk_ctl("idle", 1'b0, 1'b0);
        nx();

        // Directed cases
        txn(2'b00, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 32'd0, 32'd10, 0, 0, 0);
        txn(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 0);
        txn(2'b11, 32'd1, 32'd1, 32'd0, 32'd0, 32'd5, 32'd5, 0, 0, 0);
        txn(2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd7, 32'd7, 0, 0, 0);
        txn(2'b00, 32'd1, 32'd1, 32'd0, 32'd20, 32'd0, 32'd10, 0, 0, 0);
        txn(2'b00, 32'd7, 32'd9, 32'd1, 32'd2, 32'd0, 32'd0, 0, 3, 0);
        txn(2'b01, 32'd4, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 2, 0, 0);

        // Flush in ACC with start still high
        start = 1'b1; op = 2'b00; reg1 = 32'd3; reg2 = 32'd3; hi_i = '0; lo_i = '0;
        nx(); nx();
        flush = 1'b1;
        nx();
        flush = 1'b0; hold = 1'b1;
        @(negedge clk);
        chk("flush.stallreq", {63'd0, stallreq}, 64'd1);
        chk("flush.out", {31'd0, whilo, hi_o, lo_o}, 64'd0);
        nx();
        hold = 1'b0; start = 1'b0;
        chk_ctl("flush.idle", 1'b0, 1'b0);
        nx();

        // rst in MUL
        start = 1'b1; op = 2'b01; reg1 = 32'd8; reg2 = 32'd8;
        nx();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmul.out", {30'd0, stallreq, whilo, hi_o, lo_o}, 64'd0);
        nx();
        rst = 1'b0; start = 1'b0;
        chk_ctl("rstmul.idle", 1'b0, 1'b0);
        nx();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            txn(2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 1), $urandom_range(0, 2), 1);
        end

        repeat (3) nx();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
